// File: rtl/enc_dec_pkg.sv
// Shared types and helpers for the extended-Hamming (SECDED) encoder/decoder core.
// Maps data bits onto Hamming positions and back for the three supported codeword widths.
package enc_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENC   = 3'd1,
    ST_NOISE = 3'd2,
    ST_DEC   = 3'd3,
    ST_DONE  = 3'd4
  } enc_dec_state_t;

  typedef enum logic [1:0] {
    OP_ENC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_FULL = 2'b10,
    OP_RSVD = 2'b11
  } enc_dec_op_t;

  typedef enum logic [1:0] {
    CW_8      = 2'b00,
    CW_16     = 2'b01,
    CW_32     = 2'b10,
    CW_32_ALT = 2'b11
  } cw_width_t;

  localparam int unsigned N8  = 32'd8;
  localparam int unsigned N16 = 32'd16;
  localparam int unsigned N32 = 32'd32;
  localparam int unsigned K8  = 32'd4;
  localparam int unsigned K16 = 32'd11;
  localparam int unsigned K32 = 32'd26;

  function automatic int unsigned cw_n(input cw_width_t w);
    case (w)
      CW_8:    return N8;
      CW_16:   return N16;
      default: return N32;
    endcase
  endfunction

  // Ones in bits [n-1:0].
  function automatic logic [31:0] cw_mask(input cw_width_t w);
    case (w)
      CW_8:    return 32'h0000_00FF;
      CW_16:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Spread data bits over the non-power-of-two positions below n (position p -> bit p-1).
  function automatic logic [30:0] data_to_pos(input logic [31:0] data, input cw_width_t w);
    logic [30:0] pos;
    int unsigned j;
    pos = 31'd0;
    j   = 32'd0;
    for (int unsigned p = 32'd1; p < 32'd32; p++) begin
      if ((p < cw_n(w)) && ((p & (p - 32'd1)) != 32'd0)) begin
        pos[5'(p - 32'd1)] = data[5'(j)];
        j = j + 32'd1;
      end
    end
    return pos;
  endfunction

  function automatic logic [31:0] pos_to_data(input logic [30:0] pos, input cw_width_t w);
    logic [31:0] data;
    int unsigned j;
    data = 32'd0;
    j    = 32'd0;
    for (int unsigned p = 32'd1; p < 32'd32; p++) begin
      if ((p < cw_n(w)) && ((p & (p - 32'd1)) != 32'd0)) begin
        data[5'(j)] = pos[5'(p - 32'd1)];
        j = j + 32'd1;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/enc_dec_parity_calc.sv
// Combinational Hamming syndrome: XOR of the indices of all set positions in a 31-bit positional word.
// With parity positions zeroed this yields the parity bits to insert during encode.
module enc_dec_parity_calc (
  input  logic [30:0] pos_word,
  output logic [4:0]  syndrome
);

  // Accumulate the position index of every set bit.
  always_comb begin
    syndrome = 5'd0;
    for (int unsigned p = 32'd1; p < 32'd32; p++) begin
      if (pos_word[5'(p - 32'd1)]) begin
        syndrome = syndrome ^ 5'(p);
      end else begin
        syndrome = syndrome;
      end
    end
  end

endmodule

// File: rtl/enc_dec_core.sv
// SECDED encode / decode / full-channel compute stage behind the APB register file.
// Optional error statistics counters are built when ENC_DEC_ERR_STATS_EN is defined.
module enc_dec_core
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD = 32  // must be at least 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] ctrl,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic [AMBA_WORD-1:0] codeword_width,
  input  logic [AMBA_WORD-1:0] noise,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors,
  output logic                 operation_done,
  output logic                 busy,
  output logic [15:0]          corr_cnt,
  output logic [15:0]          uncorr_cnt
);

  enc_dec_state_t state_r, state_s;
  enc_dec_op_t    op_r, op_in_s;
  cw_width_t      width_r, width_in_s;
  logic [31:0]    cw_r, noise_r;
  logic [31:0]    n_s;
  logic [30:0]    pos_s, pos_mask_s, calc_in_s, enc_pos_s;
  logic [4:0]     syn_s;
  logic [31:0]    enc_cw_s, corr_s, dec_data_s;
  logic [1:0]     dec_err_s;
  logic           unused_s;

  assign op_in_s    = enc_dec_op_t'(ctrl[1:0]);
  assign width_in_s = cw_width_t'(codeword_width[1:0]);
  assign n_s        = cw_n(width_r);
  assign pos_s      = data_to_pos(cw_r, width_r);
  assign pos_mask_s = 31'(cw_mask(width_r) >> 1);
  assign unused_s   = ^{ctrl, codeword_width, data_in, noise};

  // Shared syndrome unit: data layout while encoding, received word otherwise.
  always_comb begin
    if (state_r == ST_ENC) begin
      calc_in_s = pos_s;
    end else begin
      calc_in_s = cw_r[30:0] & pos_mask_s;
    end
  end

  enc_dec_parity_calc u_parity_calc (
    .pos_word (calc_in_s),
    .syndrome (syn_s)
  );

  // Parity positions past n see a zero syndrome bit, so all five may be written.
  always_comb begin
    enc_pos_s = pos_s;
    for (int unsigned i = 32'd0; i < 32'd5; i++) begin
      enc_pos_s[5'((32'd1 << i) - 32'd1)] = syn_s[3'(i)];
    end
    enc_cw_s = {1'b0, enc_pos_s};
    enc_cw_s[5'(n_s - 32'd1)] = ^enc_pos_s;
  end

  // SECDED classification and single-bit correction.
  always_comb begin
    corr_s    = cw_r;
    dec_err_s = 2'd0;
    if (^cw_r == 1'b0) begin
      if (syn_s == 5'd0) begin
        dec_err_s = 2'd0;
      end else begin
        dec_err_s = 2'd2;
      end
    end else if (32'(syn_s) > (n_s - 32'd1)) begin
      dec_err_s = 2'd2;
    end else if (syn_s == 5'd0) begin
      dec_err_s = 2'd1;
      corr_s[5'(n_s - 32'd1)] = ~cw_r[5'(n_s - 32'd1)];
    end else begin
      dec_err_s = 2'd1;
      corr_s[syn_s - 5'd1] = ~cw_r[syn_s - 5'd1];
    end
    dec_data_s = pos_to_data(corr_s[30:0], width_r);
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op_in_s)
            OP_ENC:  state_s = ST_ENC;
            OP_FULL: state_s = ST_ENC;
            OP_DEC:  state_s = ST_DEC;
            default: state_s = ST_DONE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENC: begin
        if (op_r == OP_FULL) begin
          state_s = ST_NOISE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_NOISE: state_s = ST_DEC;
      ST_DEC:   state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, captured operands and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      op_r           <= OP_ENC;
      width_r        <= CW_8;
      cw_r           <= 32'd0;
      noise_r        <= 32'd0;
      data_out       <= {AMBA_WORD{1'b0}};
      num_of_errors  <= 2'd0;
      operation_done <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_r        <= state_s;
      operation_done <= (state_s == ST_DONE);
      busy           <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op_in_s;
            width_r <= width_in_s;
            cw_r    <= data_in[31:0] & cw_mask(width_in_s);
            noise_r <= noise[31:0];
            if (op_in_s == OP_RSVD) begin
              data_out      <= {AMBA_WORD{1'b0}};
              num_of_errors <= 2'd0;
            end
          end
        end
        ST_ENC: begin
          cw_r <= enc_cw_s;
          if (op_r != OP_FULL) begin
            data_out      <= AMBA_WORD'(enc_cw_s);
            num_of_errors <= 2'd0;
          end
        end
        ST_NOISE: cw_r <= cw_r ^ (noise_r & cw_mask(width_r));
        ST_DEC: begin
          data_out      <= AMBA_WORD'(dec_data_s);
          num_of_errors <= dec_err_s;
        end
        default: cw_r <= cw_r;
      endcase
    end
  end

`ifdef ENC_DEC_ERR_STATS_EN
  // Saturating per-outcome counters, sampled in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= 16'd0;
      uncorr_cnt <= 16'd0;
    end else begin
      if (operation_done && (num_of_errors == 2'd1) && (corr_cnt != 16'hFFFF)) begin
        corr_cnt <= corr_cnt + 16'd1;
      end
      if (operation_done && (num_of_errors == 2'd2) && (uncorr_cnt != 16'hFFFF)) begin
        uncorr_cnt <= uncorr_cnt + 16'd1;
      end
    end
  end
`else
  assign corr_cnt   = 16'd0;
  assign uncorr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_enc_dec_core.sv
// Directed scoreboard bench for enc_dec_core: expected results are queued at start and
// matched against each operation_done pulse, including its cycle of arrival.
module tb_enc_dec_core;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          due;
    bit          chk_data;
    int          id;
  } exp_t;

  logic        clk, rst, start;
  logic [31:0] ctrl, data_in, codeword_width, noise, data_out;
  logic [1:0]  num_of_errors;
  logic        operation_done, busy;
  logic [15:0] corr_cnt, uncorr_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  enc_dec_core #(.AMBA_WORD(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .noise          (noise),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .operation_done (operation_done),
    .busy           (busy),
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (operation_done === 1'b1) begin
      chk("done_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk_data) chk($sformatf("op%0d_data", mon_e.id), data_out, mon_e.data);
        chk($sformatf("op%0d_errors", mon_e.id), 32'(num_of_errors), 32'(mon_e.err));
        chk($sformatf("op%0d_done_cycle", mon_e.id), 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(negedge clk);
    chk("done_timeout", 32'(sb_q.size()), 32'd0);
    if (sb_q.size() != 0) sb_q.delete();
    @(negedge clk);
  endtask

  task automatic run_op(input int id, input logic [1:0] c, input logic [31:0] d,
                        input logic [1:0] w, input logic [31:0] nz, input logic [31:0] ed,
                        input logic [1:0] ee, input int lat, input bit cd);
    exp_t e;
    @(negedge clk);
    ctrl = {30'd0, c}; data_in = d; codeword_width = {30'd0, w}; noise = nz; start = 1'b1;
    e.data = ed; e.err = ee; e.due = cyc + lat; e.chk_data = cd; e.id = id;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("op%0d_busy", id), 32'(busy), 32'd1);
    wait_drain();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0;
    ctrl = 32'd0; data_in = 32'd0; codeword_width = 32'd0; noise = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_errors", 32'(num_of_errors), 32'd0);
    chk("rst_done", 32'(operation_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1,  2'b00, 32'h0000_000B, 2'b00, 32'h0,        32'h55,        2'd0, 2, 1'b1);
    run_op(2,  2'b01, 32'h0000_0055, 2'b00, 32'h0,        32'hB,         2'd0, 2, 1'b1);
    run_op(3,  2'b01, 32'h0000_0051, 2'b00, 32'h0,        32'hB,         2'd1, 2, 1'b1);
    run_op(4,  2'b10, 32'h0000_000B, 2'b00, 32'h04,       32'hB,         2'd1, 4, 1'b1);
    run_op(5,  2'b10, 32'h0000_000B, 2'b00, 32'h80,       32'hB,         2'd1, 4, 1'b1);
    run_op(6,  2'b10, 32'h0000_000B, 2'b00, 32'h05,       32'h0,         2'd2, 4, 1'b0);
    run_op(7,  2'b10, 32'h03FF_FFFF, 2'b10, 32'h0,        32'h03FF_FFFF, 2'd0, 4, 1'b1);
    run_op(8,  2'b10, 32'h0000_000B, 2'b00, 32'hFFFF_FFFF, 32'h4,        2'd0, 4, 1'b1);
    run_op(9,  2'b00, 32'hFFFF_FFFF, 2'b01, 32'h0,        32'hFFFF,      2'd0, 2, 1'b1);
    run_op(10, 2'b01, 32'hFFFF_FFFF, 2'b11, 32'h0,        32'h03FF_FFFF, 2'd0, 2, 1'b1);
    run_op(11, 2'b11, 32'h1234_5678, 2'b00, 32'h0,        32'h0,         2'd0, 1, 1'b1);

    // start and data_in changing while busy must not disturb the encode
    @(negedge clk);
    ctrl = 32'd0; data_in = 32'hB; codeword_width = 32'd0; noise = 32'd0; start = 1'b1;
    e.data = 32'h55; e.err = 2'd0; e.due = cyc + 2; e.chk_data = 1'b1; e.id = 12;
    sb_q.push_back(e);
    @(negedge clk);
    chk("busy_mid_op", 32'(busy), 32'd1);
    ctrl = 32'd1; data_in = 32'h1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("hold_data_out", data_out, 32'h55);
    chk("idle_busy", 32'(busy), 32'd0);

    // reset in the middle of a full-channel run
    @(negedge clk);
    ctrl = 32'd2; data_in = 32'hB; codeword_width = 32'd0; noise = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data_out", data_out, 32'd0);
    chk("midrst_errors", 32'(num_of_errors), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(operation_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    run_op(13, 2'b01, 32'h0000_0051, 2'b00, 32'h0, 32'hB, 2'd1, 2, 1'b1);
    run_op(14, 2'b10, 32'h0000_000B, 2'b00, 32'h04, 32'hB, 2'd1, 4, 1'b1);
    run_op(15, 2'b10, 32'h0000_000B, 2'b00, 32'h80, 32'hB, 2'd1, 4, 1'b1);
    run_op(16, 2'b01, 32'h0000_0050, 2'b00, 32'h0, 32'h0, 2'd2, 2, 1'b0);
    repeat (2) @(negedge clk);
`ifdef ENC_DEC_ERR_STATS_EN
    chk("corr_cnt", 32'(corr_cnt), 32'd3);
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'd1);
`else
    chk("corr_cnt", 32'(corr_cnt), 32'd0);
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_dec_core.md
# enc_dec_core

Computation stage directly downstream of the APB register file in the encoder/decoder. It takes the register-file outputs `ctrl`, `data_in`, `codeword_width` and `noise`, plus a start pulse raised on a `ctrl` write, and runs an extended-Hamming (SECDED) encode, decode, or full-channel (encode, add noise, decode) operation through a small FSM. It reports `data_out`, `num_of_errors` and a one-cycle `operation_done`.

## Interface
- `AMBA_WORD`, default 32: width of the register and data ports.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; the register file drives it for an APB write to `ctrl`.
- `ctrl`  in  AMBA_WORD  bits [1:0]: 00 encode, 01 decode, 10 full channel, 11 reserved.
- `data_in`  in  AMBA_WORD  payload or codeword to process.
- `codeword_width`  in  AMBA_WORD  bits [1:0]: 00 → n=8, 01 → n=16, 10 and 11 → n=32.
- `noise`  in  AMBA_WORD  error mask, full-channel mode only.
- `data_out`  out  AMBA_WORD  result, zero-extended; reset 0.
- `num_of_errors`  out  2  0, 1 or 2 errors detected; reset 0.
- `operation_done`  out  1  one-cycle completion pulse; reset 0.
- `busy`  out  1  high whenever the FSM is not in IDLE; reset 0.
- `corr_cnt`  out  16  corrected-decode counter (see Configuration); reset 0.
- `uncorr_cnt`  out  16  uncorrectable-decode counter (see Configuration); reset 0.

## Operation

Codeword layout:
- Hamming positions 1..n-1 map to `cw[p-1]`.
- Parity bits sit at the power-of-two positions.
- Data bits fill the remaining positions in ascending order, starting from `data_in[0]`. This gives k = 4, 11 and 26 data bits for n = 8, 16 and 32.
- `cw[n-1]` is the overall even parity over `cw[n-2:0]`.

Start and capture:
- `start` is sampled in IDLE only.
- On `start`, `ctrl`, `data_in`, `codeword_width` and `noise` are latched.
- Later register writes do not affect the running operation.

FSM states: IDLE, ENC, NOISE, DEC, DONE.
- Encode: IDLE→ENC→DONE.
  - Result: `data_out` = codeword, zero above n.
  - `num_of_errors` = 0.
- Decode: IDLE→DEC→DONE.
  - The input is `data_in[n-1:0]`.
  - s = syndrome over positions 1..n-1.
  - P = XOR of all n bits.
  - P=0, s=0: 0 errors.
  - P=1: 1 error; flip position s (s=0 means `cw[n-1]`).
  - P=0, s≠0: 2 errors, no correction.
  - Result: `data_out` = the k extracted data bits, zero-extended.
  - If s > n-1 with P=1, the error is reported as 2, uncorrected.
- Full channel: IDLE→ENC→NOISE→DEC→DONE.
  - NOISE XORs `noise[n-1:0]` into the encoded word; bits above n are ignored.
- Reserved op (11): IDLE→DONE.
  - Result: `data_out` = 0, `num_of_errors` = 0.
- DONE: asserts `operation_done`, then returns to IDLE.

Boundary rules:
- `start` while busy is ignored; it is neither queued nor allowed to corrupt the current operation.
- `rst` mid-operation returns the FSM to IDLE and zeroes all outputs immediately.
- `data_out` and `num_of_errors` hold their values until the next DONE.

## Timing
- Take `start` high in cycle t (sampled at the edge ending t).
- `operation_done` is high during:
  - t+2 for encode and decode;
  - t+4 for full channel;
  - t+1 for the reserved op.
- `data_out` and `num_of_errors` are registered and valid in the same cycle as `operation_done`.
- `busy` is high from t+1 through the DONE cycle inclusive.
- The earliest accepted next `start` is in the cycle after DONE.

## Configuration
Macro: `ENC_DEC_ERR_STATS_EN`.
- Defined:
  - `corr_cnt` increments on every DONE whose result has `num_of_errors`=1.
  - `uncorr_cnt` increments on every DONE whose result has `num_of_errors`=2.
  - Both counters are 16-bit, saturate at 0xFFFF, and are cleared by `rst`.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `enc_dec_pkg` holds:
  - state enum `enc_dec_state_t`;
  - op enum `enc_dec_op_t`;
  - width enum `cw_width_t`;
  - localparams for the k and n values per width.
- Sub-module `enc_dec_parity_calc`: combinational. It takes a 31-bit positional word and returns the 5-bit syndrome/parity vector. One instance serves both encode and syndrome computation.

## Test plan
- Encode, n=8, `data_in`=0xB → `data_out`=0x55, errors=0, done at t+2.
- Decode, n=8, `data_in`=0x55 → `data_out`=0xB, errors=0. Decode of 0x51 (bit 2 flipped) → 0xB, errors=1.
- Full channel, n=8, data 0xB:
  - noise 0x04 → 0xB, errors=1;
  - noise 0x80 → 0xB, errors=1;
  - noise 0x05 → errors=2.
  - Done at t+4 in all three cases.
- Full channel, n=32, data 0x3FFFFFF, noise 0 → 0x3FFFFFF, errors=0. Noise 0xFFFFFFFF with n=8 only affects bits [7:0].
- `start` pulsed at t+1 during an encode → a single done at t+2 only. Changing `data_in` at t+1 leaves the result unchanged.
- `rst` asserted at t+2 of a full-channel operation → outputs 0 and `busy`=0 immediately, no done. With `ENC_DEC_ERR_STATS_EN`, three single-error runs give `corr_cnt`=3.
